// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader feeding the instruction-memory write port.
// Accepts SYNC, LEN_LO, LEN_HI, then 4*N payload bytes (little-endian words),
// writes each assembled word to imem and keeps the core in reset until the image
// is complete. Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Handshake: a byte transfers on a rising clk edge where in_valid & in_ready;
// in_ready drops only during the single WRITE cycle, and the source must hold
// its byte until it is accepted.
module imem_loader #(
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam int                IDLE_W   = $clog2(TIMEOUT_CYC);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE} state_t;
`endif

    state_t            state;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   word_cnt;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_q;
    logic [IDLE_W-1:0] idle_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q;
`endif

    logic              hs;
    logic [15:0]       len_n;
    logic              len_bad;
    logic [ADDR_W:0]   word_nxt;
    logic              cnt_state;
    logic              timed_out;

    // Handshake, length decode and idle-timeout qualification.
    always_comb begin
        hs       = in_valid & in_ready;
        len_n    = {in_data, len_lo};
        len_bad  = (len_n == 16'd0) || ({16'd0, len_n} > DEPTH);
        word_nxt = word_cnt + {{ADDR_W{1'b0}}, 1'b1};
`ifdef IMEM_LOADER_CHECKSUM_EN
        cnt_state = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHK);
`else
        cnt_state = (state == LEN0) || (state == LEN1) || (state == DATA);
`endif
        timed_out = cnt_state && !hs && (idle_cnt == IDLE_MAX);
    end

    // Loader FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len_lo    <= '0;
            len_q     <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            idle_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
            in_ready  <= 1'b1;
            we_o      <= 1'b0;
            waddr_o   <= '0;
            wdata_o   <= '0;
            cpu_rst_o <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            if (cnt_state) begin
                idle_cnt <= hs ? '0 : idle_cnt + 1'b1;
            end
            if (timed_out) begin
                // Abandon the frame; whatever was already written stays in imem.
                state  <= IDLE;
                err_o  <= 1'b1;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (hs && in_data == SYNC_BYTE) begin
                            state     <= LEN0;
                            busy_o    <= 1'b1;
                            cpu_rst_o <= 1'b1;
                            err_o     <= 1'b0;
                            done_o    <= 1'b0;
                            word_cnt  <= '0;
                            byte_cnt  <= '0;
                            idle_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            xor_q     <= '0;
`endif
                        end
                    end
                    LEN0: begin
                        if (hs) begin
                            len_lo <= in_data;
                            state  <= LEN1;
                        end
                    end
                    LEN1: begin
                        if (hs) begin
                            len_q <= len_n[ADDR_W:0];
                            if (len_bad) begin
                                state  <= IDLE;
                                err_o  <= 1'b1;
                                busy_o <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (hs) begin
                            asm_q[{byte_cnt, 3'b000} +: 8] <= in_data;
                            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            xor_q    <= xor_q ^ in_data;
`endif
                            if (byte_cnt == 2'd3) begin
                                state    <= WRITE;
                                in_ready <= 1'b0;
                                we_o     <= 1'b1;
                                waddr_o  <= word_cnt[ADDR_W-1:0];
                                wdata_o  <= {in_data, asm_q[23:0]};
                            end
                        end
                    end
                    WRITE: begin
                        we_o     <= 1'b0;
                        in_ready <= 1'b1;
                        word_cnt <= word_nxt;
                        if (word_nxt == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state     <= CHK;
`else
                            state     <= DONE;
                            cpu_rst_o <= 1'b0;
                            done_o    <= 1'b1;
                            busy_o    <= 1'b0;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    CHK: begin
                        if (hs) begin
                            busy_o <= 1'b0;
                            if (in_data == xor_q) begin
                                state     <= DONE;
                                cpu_rst_o <= 1'b0;
                                done_o    <= 1'b1;
                            end else begin
                                state <= IDLE;
                                err_o <= 1'b1;
                            end
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
